// File: rtl/alu_rs_pkg.sv
// Shared widths, constants and entry layout for the ALU reservation station.
// Optional feature macro used by the station: ALU_RS_OLDEST_FIRST_EN.
package alu_rs_pkg;

   localparam int OP_W         = 6;
   localparam int DATA_W       = 32;
   localparam int ROB_TAG_W    = 4;
   localparam int RS_SIZE_DEF  = 8;
   localparam int RS_IDX_W_DEF = 3;

   localparam logic FALSE = 1'b0;
   localparam logic TRUE  = 1'b1;
   localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

   typedef struct packed {
      logic              busy;
      logic [DATA_W-1:0] val;
   } operand_t;

   typedef struct packed {
      logic                 busy;
      logic [OP_W-1:0]      op;
      logic [DATA_W-1:0]    vj;
      logic                 qj_busy;
      logic [ROB_TAG_W-1:0] qj;
      logic [DATA_W-1:0]    vk;
      logic                 qk_busy;
      logic [ROB_TAG_W-1:0] qk;
      logic [DATA_W-1:0]    pc;
      logic [DATA_W-1:0]    imm;
      logic [ROB_TAG_W-1:0] rob_tag;
   } rs_entry_t;

   localparam rs_entry_t EMPTY_ENTRY = {$bits(rs_entry_t){1'b0}};

   // A pending operand snoops both CDBs; the ALU bus wins if both carry its tag.
   function automatic operand_t operand_capture(
      input logic                 pend_i,
      input logic [ROB_TAG_W-1:0] tag_i,
      input logic [DATA_W-1:0]    val_i,
      input logic                 alu_ena_i,
      input logic [ROB_TAG_W-1:0] alu_tag_i,
      input logic [DATA_W-1:0]    alu_data_i,
      input logic                 lsb_ena_i,
      input logic [ROB_TAG_W-1:0] lsb_tag_i,
      input logic [DATA_W-1:0]    lsb_data_i
   );
      operand_t res;
      res.busy = pend_i;
      res.val  = val_i;
      if (pend_i && alu_ena_i && (alu_tag_i == tag_i)) begin
         res.busy = FALSE;
         res.val  = alu_data_i;
      end else if (pend_i && lsb_ena_i && (lsb_tag_i == tag_i)) begin
         res.busy = FALSE;
         res.val  = lsb_data_i;
      end else begin
         res.busy = pend_i;
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Combinational picker: lowest requesting index, or oldest requester when
// ALU_RS_OLDEST_FIRST_EN is defined (ties resolved toward the lower index).
module alu_rs_select
   import alu_rs_pkg::*;
#(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req_i,
`ifdef ALU_RS_OLDEST_FIRST_EN
   input  logic [IDX_W:0]   age_i [N],
`endif
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   // Linear scan keeps the first hit unless a strictly older one follows.
   always_comb begin
      logic             found_v;
      logic [IDX_W-1:0] idx_v;
`ifdef ALU_RS_OLDEST_FIRST_EN
      logic [IDX_W:0]   best_age_v;
      best_age_v = {(IDX_W+1){1'b0}};
`endif
      found_v = FALSE;
      idx_v   = {IDX_W{1'b0}};
      for (int i = 0; i < N; i++) begin
`ifdef ALU_RS_OLDEST_FIRST_EN
         if (req_i[i] && (!found_v || (age_i[i] > best_age_v))) begin
            found_v    = TRUE;
            idx_v      = IDX_W'(i);
            best_age_v = age_i[i];
         end else begin
            found_v = found_v;
         end
`else
         if (req_i[i] && !found_v) begin
            found_v = TRUE;
            idx_v   = IDX_W'(i);
         end else begin
            found_v = found_v;
         end
`endif
      end
      found_o = found_v;
      idx_o   = idx_v;
   end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds ops until operands arrive over the CDBs and
// issues one ready op per cycle. Macro ALU_RS_OLDEST_FIRST_EN enables age-based issue.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_SIZE  = RS_SIZE_DEF,
   parameter int RS_IDX_W = RS_IDX_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 disp_ena,
   input  logic [OP_W-1:0]      disp_op,
   input  logic [DATA_W-1:0]    disp_vj,
   input  logic                 disp_qj_busy,
   input  logic [ROB_TAG_W-1:0] disp_qj,
   input  logic [DATA_W-1:0]    disp_vk,
   input  logic                 disp_qk_busy,
   input  logic [ROB_TAG_W-1:0] disp_qk,
   input  logic [DATA_W-1:0]    disp_pc,
   input  logic [DATA_W-1:0]    disp_imm,
   input  logic [ROB_TAG_W-1:0] disp_rob_tag,
   output logic                 rs_full,
   input  logic                 alu_cdb_ena,
   input  logic [ROB_TAG_W-1:0] alu_cdb_tag,
   input  logic [DATA_W-1:0]    alu_cdb_data,
   input  logic                 lsb_cdb_ena,
   input  logic [ROB_TAG_W-1:0] lsb_cdb_tag,
   input  logic [DATA_W-1:0]    lsb_cdb_data,
   output logic                 alu_ena,
   output logic [OP_W-1:0]      alu_op,
   output logic [DATA_W-1:0]    alu_a,
   output logic [DATA_W-1:0]    alu_b,
   output logic [DATA_W-1:0]    alu_pc,
   output logic [DATA_W-1:0]    alu_imm,
   output logic [ROB_TAG_W-1:0] alu_rob_tag
);

   rs_entry_t ent_q [RS_SIZE];
   rs_entry_t ent_d [RS_SIZE];

   logic [RS_SIZE-1:0]  busy_s;
   logic [RS_SIZE-1:0]  ready_s;
   logic [RS_SIZE-1:0]  free_s;
   logic                issue_found_s;
   logic [RS_IDX_W-1:0] issue_idx_s;
   logic                free_found_s;
   logic [RS_IDX_W-1:0] free_idx_s;
   logic                dispatch_go_s;

   logic                 alu_ena_q;
   logic [OP_W-1:0]      alu_op_q;
   logic [DATA_W-1:0]    alu_a_q;
   logic [DATA_W-1:0]    alu_b_q;
   logic [DATA_W-1:0]    alu_pc_q;
   logic [DATA_W-1:0]    alu_imm_q;
   logic [ROB_TAG_W-1:0] alu_rob_tag_q;

`ifdef ALU_RS_OLDEST_FIRST_EN
   localparam int AGE_W = RS_IDX_W + 1;
   logic [AGE_W-1:0] age_q [RS_SIZE];
   logic [AGE_W-1:0] age_d [RS_SIZE];
   logic [AGE_W-1:0] zero_age_s [RS_SIZE];

   function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age_i);
      if (age_i == {AGE_W{1'b1}}) begin
         return age_i;
      end else begin
         return age_i + AGE_W'(1);
      end
   endfunction
`endif

   // Occupancy and readiness vectors from registered entry state.
   always_comb begin
      busy_s  = {RS_SIZE{1'b0}};
      ready_s = {RS_SIZE{1'b0}};
      free_s  = {RS_SIZE{1'b0}};
      for (int i = 0; i < RS_SIZE; i++) begin
         busy_s[i]  = ent_q[i].busy;
         ready_s[i] = ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
         free_s[i]  = !ent_q[i].busy;
      end
   end

   assign rs_full       = &busy_s;
   assign dispatch_go_s = disp_ena && free_found_s;

   alu_rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_issue_sel (
      .req_i   (ready_s),
`ifdef ALU_RS_OLDEST_FIRST_EN
      .age_i   (age_q),
`endif
      .found_o (issue_found_s),
      .idx_o   (issue_idx_s)
   );

   alu_rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
      .req_i   (free_s),
`ifdef ALU_RS_OLDEST_FIRST_EN
      .age_i   (zero_age_s),
`endif
      .found_o (free_found_s),
      .idx_o   (free_idx_s)
   );

   // Per-entry next state: issue frees, busy entries wake, the chosen free slot fills.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         ent_d[i] = ent_q[i];
         if (issue_found_s && (issue_idx_s == RS_IDX_W'(i))) begin
            ent_d[i].busy = FALSE;
         end else if (ent_q[i].busy) begin
            {ent_d[i].qj_busy, ent_d[i].vj} = operand_capture(
               ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj,
               alu_cdb_ena, alu_cdb_tag, alu_cdb_data,
               lsb_cdb_ena, lsb_cdb_tag, lsb_cdb_data);
            {ent_d[i].qk_busy, ent_d[i].vk} = operand_capture(
               ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk,
               alu_cdb_ena, alu_cdb_tag, alu_cdb_data,
               lsb_cdb_ena, lsb_cdb_tag, lsb_cdb_data);
         end else if (dispatch_go_s && (free_idx_s == RS_IDX_W'(i))) begin
            ent_d[i].busy    = TRUE;
            ent_d[i].op      = disp_op;
            ent_d[i].qj      = disp_qj;
            ent_d[i].qk      = disp_qk;
            ent_d[i].pc      = disp_pc;
            ent_d[i].imm     = disp_imm;
            ent_d[i].rob_tag = disp_rob_tag;
            {ent_d[i].qj_busy, ent_d[i].vj} = operand_capture(
               disp_qj_busy, disp_qj, disp_vj,
               alu_cdb_ena, alu_cdb_tag, alu_cdb_data,
               lsb_cdb_ena, lsb_cdb_tag, lsb_cdb_data);
            {ent_d[i].qk_busy, ent_d[i].vk} = operand_capture(
               disp_qk_busy, disp_qk, disp_vk,
               alu_cdb_ena, alu_cdb_tag, alu_cdb_data,
               lsb_cdb_ena, lsb_cdb_tag, lsb_cdb_data);
         end else begin
            ent_d[i] = ent_q[i];
         end
      end
   end

   // Entry storage and the registered issue bundle; flush clears like reset.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            ent_q[i] <= EMPTY_ENTRY;
         end
         alu_ena_q     <= FALSE;
         alu_op_q      <= {OP_W{1'b0}};
         alu_a_q       <= ZERO_DATA;
         alu_b_q       <= ZERO_DATA;
         alu_pc_q      <= ZERO_DATA;
         alu_imm_q     <= ZERO_DATA;
         alu_rob_tag_q <= {ROB_TAG_W{1'b0}};
      end else begin
         ent_q <= ent_d;
         if (issue_found_s) begin
            alu_ena_q     <= TRUE;
            alu_op_q      <= ent_q[issue_idx_s].op;
            alu_a_q       <= ent_q[issue_idx_s].vj;
            alu_b_q       <= ent_q[issue_idx_s].vk;
            alu_pc_q      <= ent_q[issue_idx_s].pc;
            alu_imm_q     <= ent_q[issue_idx_s].imm;
            alu_rob_tag_q <= ent_q[issue_idx_s].rob_tag;
         end else begin
            alu_ena_q <= FALSE;
         end
      end
   end

`ifdef ALU_RS_OLDEST_FIRST_EN
   // Ages count while an entry is occupied; a free slot sits at zero for its next dispatch.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         zero_age_s[i] = {AGE_W{1'b0}};
         if (ent_q[i].busy) begin
            age_d[i] = age_inc(age_q[i]);
         end else begin
            age_d[i] = {AGE_W{1'b0}};
         end
      end
   end

   // Age register file.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            age_q[i] <= {AGE_W{1'b0}};
         end
      end else begin
         age_q <= age_d;
      end
   end
`endif

   assign alu_ena     = alu_ena_q;
   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_pc      = alu_pc_q;
   assign alu_imm     = alu_imm_q;
   assign alu_rob_tag = alu_rob_tag_q;

endmodule
